sdram_responder: RTL and testbench

Synthesizable device-side model of a single 16-bit SDR SDRAM (MT48LC16M16 command set), the responder to our SDRAM controller. It decodes RAS/CAS/WE commands from the controller pins, tracks per-bank open rows and the mode register, and serves single-beat reads and writes from an on-chip block-RAM store. Protocol violations are flagged. It replaces the external chip in simulation and in loopback builds.

---
 rtl/sdram_pkg.sv | 40 ++++
 rtl/sdram_resp_bank.sv | 43 ++++
 rtl/sdram_responder.sv | 166 ++++++++++++++++
 tb/tb_sdram_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared command encodings, mode-register field positions and error flag
// indices for the SDR SDRAM responder model.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD_MODE    = 3'b000,
    CMD_AUTO_REFRESH = 3'b001,
    CMD_PRECHARGE    = 3'b010,
    CMD_ACTIVE       = 3'b011,
    CMD_WRITE        = 3'b100,
    CMD_READ         = 3'b101,
    CMD_BURST_TERM   = 3'b110,
    CMD_NOP          = 3'b111
  } sdram_cmd_e;

  localparam int unsigned MR_BL_LSB = 0;
  localparam int unsigned MR_BL_W   = 3;
  localparam int unsigned MR_CL_LSB = 4;
  localparam int unsigned MR_CL_W   = 3;
  localparam int unsigned MR_WB_BIT = 9;
  localparam int unsigned AP_BIT    = 10;

  localparam int unsigned ERR_NOMODE = 0;
  localparam int unsigned ERR_IDLE   = 1;
  localparam int unsigned ERR_TRCD   = 2;
  localparam int unsigned ERR_REACT  = 3;
  localparam int unsigned ERR_MODE   = 4;
  localparam int unsigned ERR_OPEN   = 5;
  localparam int unsigned ERR_W      = 6;

  // Only single-beat bursts with CAS latency 2 or 3 are modelled.
  function automatic logic mode_supported(input logic [12:0] a);
    logic [MR_BL_W-1:0] bl;
    logic [MR_CL_W-1:0] cl;
    bl = a[MR_BL_LSB +: MR_BL_W];
    cl = a[MR_CL_LSB +: MR_CL_W];
    return (bl == '0) && ((cl == 3'd2) || (cl == 3'd3));
  endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// Per-bank state: open flag, open row and a saturating ACTIVE-to-access
// counter used to flag tRCD violations.
module sdram_resp_bank
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_BITS = 3,
  parameter int unsigned T_RCD    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                activate,
  input  logic                close,
  input  logic [ROW_BITS-1:0] row_in,
  output logic                is_open,
  output logic [ROW_BITS-1:0] row,
  output logic                rcd_ok
);

  localparam int unsigned CW = (T_RCD < 1) ? 1 : $clog2(T_RCD + 1);

  logic [CW-1:0] rcd_cnt;

  // Counter loads 1 at ACTIVE so that at the k-th edge afterwards it reads k.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_open <= 1'b0;
      row     <= '0;
      rcd_cnt <= '0;
    end else if (activate) begin
      is_open <= 1'b1;
      row     <= row_in;
      rcd_cnt <= CW'(1);
    end else begin
      if (close)
        is_open <= 1'b0;
      if (is_open && (rcd_cnt < CW'(T_RCD)))
        rcd_cnt <= rcd_cnt + CW'(1);
    end
  end

  assign rcd_ok = (rcd_cnt >= CW'(T_RCD));

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDR SDRAM model: command decode, four bank trackers, mode
// register, single-beat read/write store and sticky protocol error flags.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_BITS = 3,
  parameter int unsigned COL_BITS = 9,
  parameter int unsigned T_RCD    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sdram_ncs,
  input  logic              sdram_nras,
  input  logic              sdram_ncas,
  input  logic              sdram_nwe,
  input  logic [1:0]        sdram_ba,
  input  logic [12:0]       sdram_a,
  input  logic              sdram_dqml,
  input  logic              sdram_dqmh,
  input  logic [15:0]       sdram_dq_in,
  output logic [15:0]       sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic              mode_valid,
  output logic [15:0]       refresh_cnt,
  output logic [ERR_W-1:0]  err
);

  localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH = 1 << AW;

  sdram_cmd_e cmd;
  logic do_act, do_rd, do_wr, do_rw, do_pre, do_ref, do_lm;
  logic mode_ok;

  logic [3:0]          bank_open;
  logic [3:0]          bank_rcd_ok;
  logic [3:0]          bank_close;
  logic [ROW_BITS-1:0] bank_row [4];

  logic                sel_open, sel_rcd_ok, any_open;
  logic [ROW_BITS-1:0] sel_row;
  logic [AW-1:0]       addr;
  logic                mem_we, mem_re;
  logic [ERR_W-1:0]    err_set;

  logic [15:0] mem [DEPTH];
  logic [15:0] rd_word;

  logic        cl3;
  logic        s0_valid, s1_valid;
  logic [1:0]  s0_mask;
  logic [15:0] s0_beat, s1_data;
  logic        beat_valid;
  logic [15:0] beat_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^sdram_a;

  assign cmd = sdram_cmd_e'({sdram_nras, sdram_ncas, sdram_nwe});

  always_comb begin
    do_act = 1'b0;
    do_rd  = 1'b0;
    do_wr  = 1'b0;
    do_pre = 1'b0;
    do_ref = 1'b0;
    do_lm  = 1'b0;
    if (!sdram_ncs && !reset) begin
      do_act = (cmd == CMD_ACTIVE);
      do_rd  = (cmd == CMD_READ);
      do_wr  = (cmd == CMD_WRITE);
      do_pre = (cmd == CMD_PRECHARGE);
      do_ref = (cmd == CMD_AUTO_REFRESH);
      do_lm  = (cmd == CMD_LOAD_MODE);
    end
    do_rw   = do_rd | do_wr;
    mode_ok = mode_supported(sdram_a);
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    assign bank_close[b] = (sdram_ba == 2'(b)) ?
                           ((do_pre || do_rw) && sdram_a[AP_BIT]) || do_pre :
                           (do_pre && sdram_a[AP_BIT]);

    sdram_resp_bank #(
      .ROW_BITS (ROW_BITS),
      .T_RCD    (T_RCD)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .activate (do_act && (sdram_ba == 2'(b))),
      .close    (bank_close[b]),
      .row_in   (sdram_a[ROW_BITS-1:0]),
      .is_open  (bank_open[b]),
      .row      (bank_row[b]),
      .rcd_ok   (bank_rcd_ok[b])
    );
  end

  always_comb begin
    sel_open   = bank_open[sdram_ba];
    sel_rcd_ok = bank_rcd_ok[sdram_ba];
    sel_row    = bank_row[sdram_ba];
    any_open   = |bank_open;
    addr       = {sdram_ba, sel_row, sdram_a[COL_BITS-1:0]};
    mem_we     = do_wr && sel_open;
    mem_re     = do_rd && sel_open;

    err_set             = '0;
    err_set[ERR_NOMODE] = (do_act || do_rw) && !mode_valid;
    err_set[ERR_IDLE]   = do_rw && !sel_open;
    err_set[ERR_TRCD]   = do_rw && sel_open && !sel_rcd_ok;
    err_set[ERR_REACT]  = do_act && sel_open;
    err_set[ERR_MODE]   = do_lm && !mode_ok;
    err_set[ERR_OPEN]   = (do_lm || do_ref) && any_open;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (!sdram_dqml) mem[addr][7:0]  <= sdram_dq_in[7:0];
      if (!sdram_dqmh) mem[addr][15:8] <= sdram_dq_in[15:8];
    end
    rd_word <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_valid  <= 1'b0;
      cl3         <= 1'b0;
      refresh_cnt <= '0;
      err         <= '0;
    end else begin
      if (do_lm && mode_ok) begin
        mode_valid <= 1'b1;
        cl3        <= (sdram_a[MR_CL_LSB +: MR_CL_W] == 3'd3);
      end
      if (do_ref)
        refresh_cnt <= refresh_cnt + 16'd1;
      err <= err | err_set;
    end
  end

  // DQM travels with the read so masking applies to the byte lanes at the command.
  assign s0_beat    = rd_word & {{8{~s0_mask[1]}}, {8{~s0_mask[0]}}};
  assign beat_valid = cl3 ? s1_valid : s0_valid;
  assign beat_data  = cl3 ? s1_data  : s0_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid     <= 1'b0;
      s0_mask      <= '0;
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      sdram_dq_oe  <= 1'b0;
      sdram_dq_out <= '0;
    end else begin
      s0_valid     <= mem_re;
      s0_mask      <= {sdram_dqmh, sdram_dqml};
      s1_valid     <= s0_valid;
      s1_data      <= s0_beat;
      sdram_dq_oe  <= beat_valid;
      sdram_dq_out <= beat_valid ? beat_data : '0;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: a scoreboard of expected read beats
// (data and arrival cycle) plus register checks after each phase.
module tb_sdram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ncs, nras, ncas, nwe;
  logic [1:0]  ba;
  logic [12:0] a;
  logic        dqml, dqmh;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        mode_valid;
  logic [15:0] refresh_cnt;
  logic [5:0]  err;

  typedef struct {
    logic [15:0] data;
    int unsigned due;
  } beat_t;

  beat_t       sb[$];
  int unsigned cyc = 0;
  int unsigned cl  = 2;
  int          checks = 0;
  int          failures = 0;

  localparam logic [2:0] C_LM  = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;

  sdram_responder #(
    .ROW_BITS (3),
    .COL_BITS (9),
    .T_RCD    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sdram_ncs    (ncs),
    .sdram_nras   (nras),
    .sdram_ncas   (ncas),
    .sdram_nwe    (nwe),
    .sdram_ba     (ba),
    .sdram_a      (a),
    .sdram_dqml   (dqml),
    .sdram_dqmh   (dqmh),
    .sdram_dq_in  (dq_in),
    .sdram_dq_out (dq_out),
    .sdram_dq_oe  (dq_oe),
    .mode_valid   (mode_valid),
    .refresh_cnt  (refresh_cnt),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read beats are consumed here; any beat with nothing expected is a failure.
  always @(negedge clk) begin
    if (dq_oe === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected: observed beat %h at cycle %0d expected none", dq_out, cyc);
      end
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        check("beat_data", 32'(dq_out), 32'(e.data));
        check("beat_cycle", cyc, e.due);
      end
    end
  end

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                     input logic [15:0] d, input logic ml, input logic mh);
    ncs = 1'b0;
    {nras, ncas, nwe} = c;
    ba = b; a = addr; dq_in = d; dqml = ml; dqmh = mh;
    @(negedge clk);
    ncs = 1'b1;
    {nras, ncas, nwe} = 3'b111;
    dqml = 1'b0; dqmh = 1'b0;
  endtask

  task automatic rd_exp(input logic [1:0] b, input logic [12:0] addr,
                        input logic ml, input logic mh, input logic [15:0] exp);
    beat_t e;
    e.data = exp;
    e.due  = cyc + cl;
    sb.push_back(e);
    cmd(C_RD, b, addr, 16'h0, ml, mh);
  endtask

  task automatic nops(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    ncs = 1'b1; {nras, ncas, nwe} = 3'b111;
    ba = '0; a = '0; dqml = 1'b0; dqmh = 1'b0; dq_in = '0;
    nops(3);
    check("rst_oe", 32'(dq_oe), 0);
    check("rst_dq", 32'(dq_out), 0);
    check("rst_mode", 32'(mode_valid), 0);
    check("rst_ref", 32'(refresh_cnt), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b0;
    nops(1);

    cmd(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
    cmd(C_LM, 2'd0, 13'h220, 16'h0, 1'b0, 1'b0);
    cl = 2;
    check("init_mode", 32'(mode_valid), 1);
    check("init_err", 32'(err), 0);

    cmd(C_ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
    nops(2);
    cmd(C_WR, 2'd1, 13'h400 | 13'h1A3, 16'hBEEF, 1'b0, 1'b0);
    cmd(C_ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
    nops(2);
    rd_exp(2'd1, 13'h1A3, 1'b0, 1'b0, 16'hBEEF);
    nops(4);
    cmd(C_WR, 2'd1, 13'h1A3, 16'h1234, 1'b0, 1'b1);
    rd_exp(2'd1, 13'h1A3, 1'b0, 1'b0, 16'hBE34);
    nops(4);
    rd_exp(2'd1, 13'h1A3, 1'b1, 1'b0, 16'hBE00);
    cmd(C_WR, 2'd1, 13'h010, 16'hA5A5, 1'b0, 1'b0);
    nops(4);
    check("wr_err", 32'(err), 0);

    cmd(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
    cmd(C_LM, 2'd0, 13'h230, 16'h0, 1'b0, 1'b0);
    cl = 3;
    cmd(C_ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
    nops(2);
    rd_exp(2'd1, 13'h1A3, 1'b0, 1'b0, 16'hBE34);
    rd_exp(2'd1, 13'h010, 1'b0, 1'b0, 16'hA5A5);
    nops(5);
    check("cl3_err", 32'(err), 0);

    cmd(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
    repeat (3) cmd(C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    check("ref_cnt", 32'(refresh_cnt), 3);
    check("ref_err", 32'(err), 0);

    cmd(C_RD, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    nops(4);
    check("err_idle", 32'(err), 32'h02);

    cmd(C_ACT, 2'd2, 13'd1, 16'h0, 1'b0, 1'b0);
    nops(2);
    cmd(C_WR, 2'd2, 13'h400, 16'h5A5A, 1'b0, 1'b0);
    cmd(C_ACT, 2'd2, 13'd1, 16'h0, 1'b0, 1'b0);
    rd_exp(2'd2, 13'h000, 1'b0, 1'b0, 16'h5A5A);
    nops(4);
    check("err_trcd", 32'(err), 32'h06);

    cmd(C_ACT, 2'd2, 13'd1, 16'h0, 1'b0, 1'b0);
    check("err_react", 32'(err), 32'h0E);
    cmd(C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    check("err_open", 32'(err), 32'h2E);
    check("ref_cnt4", 32'(refresh_cnt), 4);

    cmd(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
    cmd(C_LM, 2'd0, 13'h021, 16'h0, 1'b0, 1'b0);
    check("err_mode", 32'(err), 32'h3E);
    check("mode_kept", 32'(mode_valid), 1);

    cmd(C_ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
    nops(2);
    rd_exp(2'd1, 13'h1A3, 1'b0, 1'b0, 16'hBE34);
    nops(5);

    cmd(C_RD, 2'd1, 13'h1A3, 16'h0, 1'b0, 1'b0);
    reset = 1'b1;
    nops(2);
    check("mid_oe", 32'(dq_oe), 0);
    check("mid_dq", 32'(dq_out), 0);
    check("mid_mode", 32'(mode_valid), 0);
    check("mid_ref", 32'(refresh_cnt), 0);
    check("mid_err", 32'(err), 0);
    reset = 1'b0;
    nops(3);

    cmd(C_ACT, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0);
    check("err_nomode", 32'(err), 32'h01);
    nops(3);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
